// File: rtl/matrix_activation_pkg.sv
// Shared constants and types for the matrix activation engine.
package matrix_activation_pkg;

  localparam int unsigned DEFAULT_TYPE_BW = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned SHIFT_W         = 5;

  // Memory request encodings seen by the SRAM controller.
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  // Saturation window for the clamp mode.
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    MODE_RELU = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_SHR  = 2'd2,
    MODE_COPY = 2'd3
  } act_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/matrix_activation_alu.sv
// Element activation: pure combinational function of mode, shift and element.
module activation_alu
  import matrix_activation_pkg::*;
#(
  parameter int unsigned TYPE_BW = DEFAULT_TYPE_BW
) (
  input  act_mode_e            i_mode,
  input  logic [SHIFT_W-1:0]   i_shift,
  input  logic [TYPE_BW-1:0]   i_x,
  output logic [TYPE_BW-1:0]   o_y_c
);

  localparam logic signed [TYPE_BW-1:0] SAT_HI = TYPE_BW'(SAT_MAX);
  localparam logic signed [TYPE_BW-1:0] SAT_LO = TYPE_BW'(SAT_MIN);

  logic signed [TYPE_BW-1:0] w_x;
  assign w_x = $signed(i_x);

  // Select the activation result; elements are signed two's complement.
  always_comb begin
    o_y_c = i_x;
    case (i_mode)
      MODE_RELU: if (w_x < 0) o_y_c = '0;
      MODE_SAT: begin
        if (w_x > SAT_HI)      o_y_c = SAT_HI;
        else if (w_x < SAT_LO) o_y_c = SAT_LO;
      end
      MODE_SHR:  o_y_c = TYPE_BW'(w_x >>> i_shift);
      MODE_COPY: o_y_c = i_x;
      default:   o_y_c = i_x;
    endcase
  end

endmodule

// File: rtl/matrix_activation.sv
// Job engine: fetches a 4-word header, then streams N elements through the
// activation ALU, one read and one write per element, no overlap.
module matrix_activation
  import matrix_activation_pkg::*;
#(
  parameter int unsigned TYPE_BW  = DEFAULT_TYPE_BW,
  parameter logic [31:0] HDR_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               done,
  output logic [1:0]         mem_operation,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [TYPE_BW-1:0] data_o,
  input  logic [TYPE_BW-1:0] data_i,
  input  logic               mem_opdone
);

  state_e               r_state;
  logic [1:0]           r_hdr_idx;
  logic [ADDR_W-1:0]    r_idx;
  logic [TYPE_BW-1:0]   r_src;
  logic [TYPE_BW-1:0]   r_dst;
  logic [TYPE_BW-1:0]   r_cnt;
  act_mode_e            r_mode;
  logic [SHIFT_W-1:0]   r_shift;
  logic                 r_done;
  logic [1:0]           r_mem_op;
  logic [ADDR_W-1:0]    r_addr;
  logic [TYPE_BW-1:0]   r_data;

  logic [TYPE_BW-1:0]   w_act;
  logic [ADDR_W-1:0]    w_idx_next;

  assign done          = r_done;
  assign mem_operation = r_mem_op;
  assign addr_o        = r_addr;
  assign data_o        = r_data;
  assign w_idx_next    = r_idx + ADDR_W'(1);

  activation_alu #(.TYPE_BW(TYPE_BW)) u_alu (
    .i_mode  (r_mode),
    .i_shift (r_shift),
    .i_x     (data_i),
    .o_y_c   (w_act)
  );

  // Job sequencer: a request is issued from an idle bus cycle and held until
  // its completion pulse; completion always returns the bus to idle for a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_hdr_idx <= 2'd0;
      r_idx     <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_mode    <= MODE_RELU;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_mem_op  <= MEM_NONE;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done   <= 1'b0;
          r_mem_op <= MEM_NONE;
          if (enable) begin
            r_state   <= ST_HDR;
            r_hdr_idx <= 2'd0;
            r_idx     <= '0;
          end
        end

        ST_HDR: begin
          if (!enable) begin
            r_state  <= ST_IDLE;
            r_mem_op <= MEM_NONE;
            r_done   <= 1'b0;
          end else if (r_mem_op == MEM_NONE) begin
            r_mem_op <= MEM_READ;
            r_addr   <= HDR_ADDR + ADDR_W'(r_hdr_idx);
          end else if (mem_opdone) begin
            r_mem_op <= MEM_NONE;
            case (r_hdr_idx)
              2'd0: r_src <= data_i;
              2'd1: r_dst <= data_i;
              2'd2: r_cnt <= data_i;
              default: begin
                r_mode  <= act_mode_e'(data_i[1:0]);
                r_shift <= data_i[12:8];
              end
            endcase
            if (r_hdr_idx == 2'd3) begin
              r_idx <= '0;
              if (r_cnt == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_RD;
              end
            end else begin
              r_hdr_idx <= r_hdr_idx + 2'd1;
            end
          end
        end

        ST_RD: begin
          if (!enable) begin
            r_state  <= ST_IDLE;
            r_mem_op <= MEM_NONE;
            r_done   <= 1'b0;
          end else if (r_mem_op == MEM_NONE) begin
            r_mem_op <= MEM_READ;
            r_addr   <= ADDR_W'(r_src) + r_idx;
          end else if (mem_opdone) begin
            r_mem_op <= MEM_NONE;
            r_data   <= w_act;
            r_state  <= ST_WR;
          end
        end

        ST_WR: begin
          if (!enable) begin
            r_state  <= ST_IDLE;
            r_mem_op <= MEM_NONE;
            r_done   <= 1'b0;
          end else if (r_mem_op == MEM_NONE) begin
            r_mem_op <= MEM_WRITE;
            r_addr   <= ADDR_W'(r_dst) + r_idx;
          end else if (mem_opdone) begin
            r_mem_op <= MEM_NONE;
            r_idx    <= w_idx_next;
            if (w_idx_next == ADDR_W'(r_cnt)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RD;
            end
          end
        end

        ST_DONE: begin
          r_mem_op <= MEM_NONE;
          if (!enable) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end else begin
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_mem_op <= MEM_NONE;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
